// File: rtl/blob_pkg.sv
// Shared types and constants for the blob centroid tracker.
// Optional bounding-box tracking is enabled in the top with BLOB_BBOX_EN.
package blob_pkg;

  localparam int unsigned SUM_W   = 28;
  localparam int unsigned CNT_W   = 19;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned CENT_W  = 10;

  // Bit positions inside the steering word
  localparam int unsigned UP    = 3;
  localparam int unsigned DOWN  = 2;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 0;

  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sx;
    logic [SUM_W-1:0] sy;
  } acc_t;

  typedef struct packed {
    logic [CENT_W-1:0] xmin;
    logic [CENT_W-1:0] xmax;
    logic [CENT_W-1:0] ymin;
    logic [CENT_W-1:0] ymax;
  } bbox_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, SUM_W cycles per divide.
// The first bit is resolved on the start cycle; done pulses once the quotient is final.
module seq_divider
  import blob_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvsr;
  logic [STEP_W-1:0] steps;

  logic [CNT_W-1:0]  rem_in_c;
  logic [CNT_W-1:0]  dvsr_in_c;
  logic [SUM_W-1:0]  quo_in_c;
  logic [CNT_W:0]    rem_sh_c;
  logic              qbit_c;
  logic [CNT_W-1:0]  rem_nx_c;
  logic [SUM_W-1:0]  quo_nx_c;

  // One restoring step; the quotient shifts into the dividend register
  always_comb begin
    rem_in_c  = start ? '0 : rem;
    quo_in_c  = start ? dividend : quotient;
    dvsr_in_c = start ? divisor : dvsr;
    rem_sh_c  = {rem_in_c, quo_in_c[SUM_W-1]};
    qbit_c    = rem_sh_c >= {1'b0, dvsr_in_c};
    rem_nx_c  = qbit_c ? CNT_W'(rem_sh_c - {1'b0, dvsr_in_c}) : rem_sh_c[CNT_W-1:0];
    quo_nx_c  = {quo_in_c[SUM_W-2:0], qbit_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvsr     <= '0;
      steps    <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_nx_c;
        quotient <= quo_nx_c;
        dvsr     <= divisor;
        steps    <= STEP_W'(SUM_W - 1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nx_c;
        quotient <= quo_nx_c;
        steps    <= steps - STEP_W'(1);
        if (steps == STEP_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/blob_centroid_tracker.sv
// Per-frame blob centroid and steering word from a colour-match pixel stream.
// Define BLOB_BBOX_EN to also publish the bounding box of matched pixels.
module blob_centroid_tracker
  import blob_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 256,
  parameter int unsigned DEADBAND   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               match,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               VGA_VS,
  output logic [CENT_W-1:0]  cent_x,
  output logic [CENT_W-1:0]  cent_y,
  output logic               cent_valid,
  output logic               frame_done,
  output logic               overrun,
  output logic [3:0]         enable
`ifdef BLOB_BBOX_EN
  ,
  output logic [CENT_W-1:0]  bbox_xmin,
  output logic [CENT_W-1:0]  bbox_xmax,
  output logic [CENT_W-1:0]  bbox_ymin,
  output logic [CENT_W-1:0]  bbox_ymax
`endif
);

  localparam int unsigned SW1 = SUM_W + 1;
  localparam logic [CENT_W-1:0] LEFT_EDGE  = CENT_W'(H_ACTIVE / 2 - DEADBAND);
  localparam logic [CENT_W-1:0] RIGHT_EDGE = CENT_W'(H_ACTIVE / 2 + DEADBAND);
  localparam logic [CENT_W-1:0] UP_EDGE    = CENT_W'(V_ACTIVE / 2 - DEADBAND);
  localparam logic [CENT_W-1:0] DOWN_EDGE  = CENT_W'(V_ACTIVE / 2 + DEADBAND);

  state_t            state, next_state;
  logic              vs_q;
  logic              frame_end_c;
  logic              pix_ok_c;
  logic              frame_ok_c;
  acc_t              acc, acc_nx_c;
  logic [SW1-1:0]    sx_sum_c, sy_sum_c;
  logic [CNT_W-1:0]  snap_cnt;
  logic [SUM_W-1:0]  snap_sy;
  logic              snap_valid;
  logic [CENT_W-1:0] qx;

  logic              div_start_c;
  logic [SUM_W-1:0]  div_dividend_c;
  logic [CNT_W-1:0]  div_divisor_c;
  logic              div_busy, div_done;
  logic [SUM_W-1:0]  div_quotient;
  logic              unused_c;

  function automatic logic [3:0] steer(input logic [CENT_W-1:0] cx, input logic [CENT_W-1:0] cy);
    logic [3:0] en;
    en        = '0;
    en[UP]    = cy < UP_EDGE;
    en[DOWN]  = cy > DOWN_EDGE;
    en[LEFT]  = cx < LEFT_EDGE;
    en[RIGHT] = cx > RIGHT_EDGE;
    return en;
  endfunction

  assign frame_end_c = vs_q & ~VGA_VS;
  assign pix_ok_c    = match & VGA_VS & (X < COORD_W'(H_ACTIVE)) & (Y < COORD_W'(V_ACTIVE));
  assign frame_ok_c  = acc_nx_c.cnt >= CNT_W'(MIN_PIXELS);
  assign unused_c    = ^{div_busy, div_quotient[SUM_W-1:CENT_W]};

  // Saturating accumulation of the current pixel
  always_comb begin
    acc_nx_c = acc;
    sx_sum_c = {1'b0, acc.sx} + SW1'(X);
    sy_sum_c = {1'b0, acc.sy} + SW1'(Y);
    if (pix_ok_c) begin
      if (acc.cnt != '1) acc_nx_c.cnt = acc.cnt + CNT_W'(1);
      acc_nx_c.sx = sx_sum_c[SUM_W] ? '1 : sx_sum_c[SUM_W-1:0];
      acc_nx_c.sy = sy_sum_c[SUM_W] ? '1 : sy_sum_c[SUM_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      vs_q       <= 1'b0;
      acc        <= '0;
      snap_cnt   <= '0;
      snap_sy    <= '0;
      snap_valid <= 1'b0;
    end else begin
      vs_q <= VGA_VS;
      acc  <= frame_end_c ? '0 : acc_nx_c;
      if (frame_end_c && state == ACCUM) begin
        snap_cnt   <= acc_nx_c.cnt;
        snap_sy    <= acc_nx_c.sy;
        snap_valid <= frame_ok_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= ACCUM;
    else        state <= next_state;
  end

  // X divide starts straight from the boundary snapshot; Y reuses the divider
  always_comb begin
    next_state     = state;
    div_start_c    = 1'b0;
    div_dividend_c = snap_sy;
    div_divisor_c  = snap_cnt;
    case (state)
      ACCUM: begin
        if (frame_end_c) begin
          if (frame_ok_c) begin
            next_state     = DIV_X;
            div_start_c    = 1'b1;
            div_dividend_c = acc_nx_c.sx;
            div_divisor_c  = acc_nx_c.cnt;
          end else begin
            next_state = PUBLISH;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          next_state  = DIV_Y;
          div_start_c = 1'b1;
        end
      end
      DIV_Y:   if (div_done) next_state = PUBLISH;
      PUBLISH: next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  seq_divider u_div (
    .clk      (CLK),
    .rst_n    (Reset),
    .start    (div_start_c),
    .dividend (div_dividend_c),
    .divisor  (div_divisor_c),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cent_x     <= '0;
      cent_y     <= '0;
      cent_valid <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      enable     <= '0;
      qx         <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_end_c && state != ACCUM) overrun <= 1'b1;
      if (state == DIV_X && div_done) qx <= div_quotient[CENT_W-1:0];
      if (state == PUBLISH) begin
        frame_done <= 1'b1;
        cent_valid <= snap_valid;
        enable     <= '0;
        if (snap_valid) begin
          cent_x <= qx;
          cent_y <= div_quotient[CENT_W-1:0];
          enable <= steer(qx, div_quotient[CENT_W-1:0]);
        end
      end
    end
  end

`ifdef BLOB_BBOX_EN
  bbox_t box, box_nx_c, box_snap;

  always_comb begin
    box_nx_c = box;
    if (pix_ok_c) begin
      if (X[CENT_W-1:0] < box.xmin) box_nx_c.xmin = X[CENT_W-1:0];
      if (X[CENT_W-1:0] > box.xmax) box_nx_c.xmax = X[CENT_W-1:0];
      if (Y[CENT_W-1:0] < box.ymin) box_nx_c.ymin = Y[CENT_W-1:0];
      if (Y[CENT_W-1:0] > box.ymax) box_nx_c.ymax = Y[CENT_W-1:0];
    end
  end

  // Box restarts empty (min all-ones, max zero) at every frame boundary
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      box       <= {{CENT_W{1'b1}}, {CENT_W{1'b0}}, {CENT_W{1'b1}}, {CENT_W{1'b0}}};
      box_snap  <= '0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else begin
      box <= frame_end_c ? {{CENT_W{1'b1}}, {CENT_W{1'b0}}, {CENT_W{1'b1}}, {CENT_W{1'b0}}}
                         : box_nx_c;
      if (frame_end_c && state == ACCUM) box_snap <= box_nx_c;
      if (state == PUBLISH) begin
        bbox_xmin <= snap_valid ? box_snap.xmin : '0;
        bbox_xmax <= snap_valid ? box_snap.xmax : '0;
        bbox_ymin <= snap_valid ? box_snap.ymin : '0;
        bbox_ymax <= snap_valid ? box_snap.ymax : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Scoreboard bench for blob_centroid_tracker: stimulus pushes expected results,
// a negedge monitor pops and compares on every frame_done.
module tb_blob_centroid_tracker;

  logic        CLK, Reset, match, VGA_VS;
  logic [10:0] X, Y;
  logic [9:0]  cent_x, cent_y;
  logic        cent_valid, frame_done, overrun;
  logic [3:0]  enable;
`ifdef BLOB_BBOX_EN
  logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`endif

  typedef struct {
    int cx;
    int cy;
    int valid;
    int en;
    int ov;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   last_cx = 0;
  int   last_cy = 0;

  blob_centroid_tracker dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .match      (match),
    .X          (X),
    .Y          (Y),
    .VGA_VS     (VGA_VS),
    .cent_x     (cent_x),
    .cent_y     (cent_y),
    .cent_valid (cent_valid),
    .frame_done (frame_done),
    .overrun    (overrun),
    .enable     (enable)
`ifdef BLOB_BBOX_EN
    ,
    .bbox_xmin  (bbox_xmin),
    .bbox_xmax  (bbox_xmax),
    .bbox_ymin  (bbox_ymin),
    .bbox_ymax  (bbox_ymax)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic m);
    match = m;
    X     = 11'(x);
    Y     = 11'(y);
    tick();
    match = 1'b0;
  endtask

  task automatic send_rect(input int x0, input int y0, input int w, input int h);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        pix(xx, yy, 1'b1);
  endtask

  // VS low for one cycle with a matching pixel that must be ignored
  task automatic frame_end(input int valid, input int cx, input int cy, input int en, input int ov);
    exp_t e;
    if (valid != 0) begin
      last_cx = cx;
      last_cy = cy;
    end
    e.cx    = last_cx;
    e.cy    = last_cy;
    e.valid = valid;
    e.en    = en;
    e.ov    = ov;
    e.due   = cyc + ((valid != 0) ? 58 : 2);
    sb.push_back(e);
    VGA_VS = 1'b0;
    match  = 1'b1;
    X      = 11'd100;
    Y      = 11'd100;
    tick();
    VGA_VS = 1'b1;
    match  = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset === 1'b1 && frame_done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_frame_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("cent_x", int'(cent_x), e.cx);
          chk("cent_y", int'(cent_y), e.cy);
          chk("cent_valid", int'(cent_valid), e.valid);
          chk("enable", int'(enable), e.en);
          chk("overrun", int'(overrun), e.ov);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b0;
    match  = 1'b0;
    VGA_VS = 1'b1;
    X      = '0;
    Y      = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cent_x", int'(cent_x), 0);
    chk("rst_cent_y", int'(cent_y), 0);
    chk("rst_cent_valid", int'(cent_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_enable", int'(enable), 0);
    Reset = 1'b1;
    repeat (3) tick();

    // Centred square: no steering
    send_rect(300, 220, 20, 20);
    frame_end(1, 309, 229, 4'b0000, 0);
    drain(100);

    // Top-left square plus pixels that must not be accumulated
    send_rect(0, 0, 20, 20);
    pix(700, 5, 1'b1);
    pix(5, 500, 1'b1);
    pix(5, 5, 1'b0);
    pix(640, 0, 1'b1);
    pix(0, 480, 1'b1);
    frame_end(1, 9, 9, 4'b1010, 0);
    drain(100);

    // Too few pixels: short path, centroid held
    send_rect(500, 400, 10, 10);
    frame_end(0, 0, 0, 4'b0000, 0);
    drain(20);

    // Left deadband edge
    send_rect(279, 230, 20, 20);
    frame_end(1, 288, 239, 4'b0000, 0);
    drain(100);
    send_rect(278, 230, 20, 20);
    frame_end(1, 287, 239, 4'b0010, 0);
    drain(100);

    // Second boundary 10 cycles after the first lands while busy
    send_rect(300, 220, 20, 20);
    frame_end(1, 309, 229, 4'b0000, 1);
    repeat (9) pix(0, 0, 1'b1);
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
    chk("overrun_set", int'(overrun), 1);
    send_rect(600, 400, 20, 20);
    frame_end(1, 609, 409, 4'b0101, 1);
    drain(100);

    // Reset in the middle of the Y divide
    send_rect(0, 0, 20, 20);
    frame_end(1, 9, 9, 4'b1010, 1);
    repeat (40) tick();
    Reset = 1'b0;
    #1;
    sb.delete();
    last_cx = 0;
    last_cy = 0;
    chk("midrst_cent_x", int'(cent_x), 0);
    chk("midrst_cent_y", int'(cent_y), 0);
    chk("midrst_cent_valid", int'(cent_valid), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_enable", int'(enable), 0);
    repeat (2) tick();
    Reset = 1'b1;
    repeat (70) tick();

    send_rect(300, 220, 20, 20);
    frame_end(1, 309, 229, 4'b0000, 0);
    drain(100);

    repeat (5) tick();
    chk("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
